data_sram_responder: RTL and testbench
======================================

# data_sram_responder

Target-side responder for the CPU data SRAM interface. Answers the core's `data_sram_*` requests with a word-organised RAM and a small block of memory-mapped configuration registers: LED, switches, free-running timer, scratch and display number. Sits beside the CPU top in the SoC wrapper, in place of a bare block RAM. Read data is registered, giving the one-cycle read latency the MEM stage expects.

## Interface
- `ADDR_W`, 12 — RAM word-address width; RAM holds 2^ADDR_W 32-bit words.
- `CONF_BASE`, 32'hbfaf_0000 — base of the configuration region; region size 64 KiB, matched on `addr[31:16]`.
- `clk`  in  1  — single clock; all state changes on its rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `data_sram_en`  in  1  — request valid this cycle.
- `data_sram_we`  in  4  — byte-lane write enables; 4'b0000 with `en` = read.
- `data_sram_addr`  in  32  — byte address; bits [1:0] ignored.
- `data_sram_wdata`  in  32  — write data; lane i = bits [8i+7:8i].
- `data_sram_rdata`  out  32  — read data, valid the cycle after a read is sampled.
- `switch`  in  8  — board switches; sampled into a register each cycle.
- `led`  out  16  — LED register value.
- `num`  out  32  — display number register value.

## Operation
- Decode:
  - `addr[31:16] == CONF_BASE[31:16]` → configuration region.
  - Otherwise → RAM at word index `addr[ADDR_W+1:2]`; upper bits are not checked, so the RAM aliases.
- Configuration offsets, `addr[15:0]`:
  - 0x0000 LED: R/W, 16 bits; upper 16 read 0.
  - 0x0004 SWITCH: RO; `{24'b0, switch_q}`.
  - 0x0008 TIMER: R/W, 32 bits; +1 every cycle.
  - 0x000C SCRATCH: R/W, 32 bits.
  - 0x0010 NUM: R/W, 32 bits.
  - Any other offset: reads return 0, writes are ignored.
- Write (`en=1`, `we!=0`):
  - Only the enabled byte lanes of the target are updated, at that edge.
  - `data_sram_rdata` holds its previous value.
- Read (`en=1`, `we=0`):
  - `data_sram_rdata` loads the target's value as it stood before the edge.
  - Holds that value until the next read is sampled.
- Idle (`en=0`): no state changes except TIMER increment and `switch_q` sampling.
- TIMER write: the lane-masked load replaces the increment for that cycle; unwritten lanes take the incremented value. Written lanes hold `wdata`, unwritten lanes hold old+1.
- TIMER wraps from 32'hffff_ffff to 0 with no flag.
- Writes to SWITCH are ignored.

## Timing
- Reset values:
  - `data_sram_rdata`: 0
  - `led`: 0
  - `num`: 0
  - TIMER: 0
  - SCRATCH: 0
  - `switch_q`: 0
  - RAM contents: not reset.
- Read latency: exactly 1 cycle. Request at edge N → data valid after edge N until the next read edge.
- Back-to-back reads: every cycle, full throughput; no stall and no handshake beyond `en`.
- Write then read of the same word on the following cycle returns the written data.
- A TIMER read sampled at edge N returns the pre-edge value T; a read at N+1 returns T+1.
- `switch` → SWITCH readable value: 1 cycle of registering, then 1 cycle of read latency.
- Reset asserted together with a request: reset wins. The request is dropped and RAM is not written.

## Structure
- Shared package holds:
  - `CONF_OFF_LED`, `CONF_OFF_SWITCH`, `CONF_OFF_TIMER`, `CONF_OFF_SCRATCH`, `CONF_OFF_NUM` constants.
  - The byte-lane merge function: old, new, we → merged.
- One sub-module, `sram_byte_we`: a parametric single-port RAM with a byte-write array and a registered read port.
- The configuration decode, registers and rdata mux stay in the top.

## Test plan
- Reset, then read addr 0x1c00_0000 after a RAM write of 32'h1234_5678 with `we`=4'hf → rdata = 32'h1234_5678 one cycle later.
- Byte lanes: RAM word holds 32'haabb_ccdd; write `we`=4'b0101 with `wdata`=32'h1122_3344 → readback 32'haa22_cc44.
- TIMER: after reset, a read at cycle 10 returns 9 or 10 consistently with the pre-edge rule. Write 32'hffff_fffe, read two cycles later → 0 (wrap).
- Config: write LED = 32'hdead_beef → `led` = 16'hbeef, readback 32'h0000_beef. Write SWITCH is ignored. `switch` = 8'h5a → SWITCH read = 32'h5a after two cycles.
- Unmapped offset 0x0100: write, then read → 0.
- Reset mid-stream: read pending with rdata ≠ 0, then assert `reset` for one cycle → rdata = 0, `led` = 0, TIMER restarts at 0.

Source files
------------

// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data SRAM responder: configuration register
// offsets and the byte-lane merge used by every writable register.
package data_sram_responder_pkg;

  localparam logic [15:0] CONF_OFF_LED     = 16'h0000;
  localparam logic [15:0] CONF_OFF_SWITCH  = 16'h0004;
  localparam logic [15:0] CONF_OFF_TIMER   = 16'h0008;
  localparam logic [15:0] CONF_OFF_SCRATCH = 16'h000c;
  localparam logic [15:0] CONF_OFF_NUM     = 16'h0010;

  // Replace each byte lane of old_val whose enable is set with the same lane of new_val.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  we);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_sram_responder_sram_byte_we.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The read register only loads on reads, so it holds across writes and idles.
module sram_byte_we #(
  parameter int ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic [3:0]        i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [3:0][7:0] r_mem [0:(1<<ADDR_W)-1];
  logic [31:0]     r_rdata;

  // Byte-lane writes, or a read of the pre-edge word into the output register.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we == 4'b0000) begin
        r_rdata <= r_mem[i_addr];
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (i_we[i]) r_mem[i_addr][i] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_sram_responder.sv
// Target-side responder for the CPU data SRAM port: word RAM plus a 64 KiB
// configuration window (LED, switches, timer, scratch, display number).
// Read data is registered, giving one cycle of read latency.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] CONF_BASE = 32'hbfaf_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic [31:0] num
);

  logic        w_is_conf;
  logic [15:0] w_off;
  logic        w_rd;
  logic        w_conf_wr;
  logic        w_ram_en;
  logic [31:0] w_ram_rdata;
  logic [31:0] w_conf_rdata;
  logic [31:0] w_led_merged;
  logic [31:0] w_timer_inc;
  logic [31:0] w_timer_nxt;

  logic [15:0] r_led;
  logic [7:0]  r_switch;
  logic [31:0] r_timer;
  logic [31:0] r_scratch;
  logic [31:0] r_num;
  logic [31:0] r_conf_rdata;
  logic        r_sel_ram;

  assign w_is_conf = (data_sram_addr[31:16] == CONF_BASE[31:16]);
  assign w_off     = data_sram_addr[15:0];
  assign w_rd      = data_sram_en && (data_sram_we == 4'b0000);
  assign w_conf_wr = data_sram_en && (data_sram_we != 4'b0000) && w_is_conf;
  // Reset must also block RAM writes, so the RAM enable is gated by it.
  assign w_ram_en  = data_sram_en && !w_is_conf && !reset;

  sram_byte_we #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (clk),
    .i_en    (w_ram_en),
    .i_we    (data_sram_we),
    .i_addr  (data_sram_addr[ADDR_W+1:2]),
    .i_wdata (data_sram_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign w_led_merged = merge_bytes({16'h0000, r_led}, data_sram_wdata, data_sram_we);
  assign w_timer_inc  = r_timer + 32'd1;

  // Timer next value: lane-masked load over the incremented value when written.
  always_comb begin
    w_timer_nxt = w_timer_inc;
    if (w_conf_wr && (w_off == CONF_OFF_TIMER))
      w_timer_nxt = merge_bytes(w_timer_inc, data_sram_wdata, data_sram_we);
  end

  // Configuration read mux on pre-edge register values; unmapped offsets read 0.
  always_comb begin
    w_conf_rdata = 32'h0000_0000;
    case (w_off)
      CONF_OFF_LED:     w_conf_rdata = {16'h0000, r_led};
      CONF_OFF_SWITCH:  w_conf_rdata = {24'h000000, r_switch};
      CONF_OFF_TIMER:   w_conf_rdata = r_timer;
      CONF_OFF_SCRATCH: w_conf_rdata = r_scratch;
      CONF_OFF_NUM:     w_conf_rdata = r_num;
      default:          w_conf_rdata = 32'h0000_0000;
    endcase
  end

  // Configuration registers, switch sampling and the read-return select.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_led        <= 16'h0000;
      r_switch     <= 8'h00;
      r_timer      <= 32'h0000_0000;
      r_scratch    <= 32'h0000_0000;
      r_num        <= 32'h0000_0000;
      r_conf_rdata <= 32'h0000_0000;
      r_sel_ram    <= 1'b0;
    end else begin
      r_switch <= switch;
      r_timer  <= w_timer_nxt;
      if (w_conf_wr) begin
        case (w_off)
          CONF_OFF_LED:     r_led     <= w_led_merged[15:0];
          CONF_OFF_SCRATCH: r_scratch <= merge_bytes(r_scratch, data_sram_wdata, data_sram_we);
          CONF_OFF_NUM:     r_num     <= merge_bytes(r_num, data_sram_wdata, data_sram_we);
          default: ;
        endcase
      end
      if (w_rd) begin
        r_sel_ram <= !w_is_conf;
        if (w_is_conf) r_conf_rdata <= w_conf_rdata;
      end
    end
  end

  assign data_sram_rdata = r_sel_ram ? w_ram_rdata : r_conf_rdata;
  assign led             = r_led;
  assign num             = r_num;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: a per-edge behavioural model of the memory
// map, a negedge compare process, and directed vectors with literal checks.
module tb_data_sram_responder;

  localparam logic [31:0] CB = 32'hbfaf_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  we = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [7:0]  sw = 8'h00;
  logic [15:0] led;
  logic [31:0] num;

  int tests = 0;
  int fails = 0;

  data_sram_responder dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (en),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .switch          (sw),
    .led             (led),
    .num             (num)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_ram [int];
  logic [31:0] m_rdata = 32'h0;
  bit          m_rvalid = 1'b0;
  bit          m_init = 1'b0;
  logic [15:0] m_led = 16'h0;
  logic [7:0]  m_sw = 8'h0;
  logic [31:0] m_timer = 32'h0;
  logic [31:0] m_scr = 32'h0;
  logic [31:0] m_num = 32'h0;

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] w);
    logic [31:0] mask;
    mask = {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  function automatic logic [31:0] conf_value(input logic [15:0] off);
    case (off)
      16'h0000: return {16'h0, m_led};
      16'h0004: return {24'h0, m_sw};
      16'h0008: return m_timer;
      16'h000c: return m_scr;
      16'h0010: return m_num;
      default:  return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [31:0] t_next;
    logic [31:0] tmp;
    int          widx;
    if (reset) begin
      m_init = 1'b1; m_rvalid = 1'b1; m_rdata = 0;
      m_led = 0; m_sw = 0; m_timer = 0; m_scr = 0; m_num = 0;
    end else begin
      t_next = m_timer + 1;
      if (en) begin
        if (addr[31:16] == CB[31:16]) begin
          if (we == 4'h0) begin
            m_rdata = conf_value(addr[15:0]);
            m_rvalid = 1'b1;
          end else begin
            case (addr[15:0])
              16'h0000: begin tmp = lanes({16'h0, m_led}, wdata, we); m_led = tmp[15:0]; end
              16'h0008: t_next = lanes(t_next, wdata, we);
              16'h000c: m_scr = lanes(m_scr, wdata, we);
              16'h0010: m_num = lanes(m_num, wdata, we);
              default: ;
            endcase
          end
        end else begin
          widx = int'(addr[13:2]);
          if (we == 4'h0) begin
            m_rvalid = m_ram.exists(widx);
            if (m_rvalid) m_rdata = m_ram[widx];
          end else begin
            tmp = m_ram.exists(widx) ? m_ram[widx] : 32'h0;
            m_ram[widx] = lanes(tmp, wdata, we);
          end
        end
      end
      m_timer = t_next;
      m_sw = sw;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_init) begin
      if (m_rvalid) begin
        tests++;
        if (rdata !== m_rdata) begin
          fails++;
          $display("FAIL model_rdata t=%0t got=%h want=%h", $time, rdata, m_rdata);
        end
      end
      tests++;
      if (led !== m_led) begin
        fails++;
        $display("FAIL model_led t=%0t got=%h want=%h", $time, led, m_led);
      end
      tests++;
      if (num !== m_num) begin
        fails++;
        $display("FAIL model_num t=%0t got=%h want=%h", $time, num, m_num);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic req(input logic e, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] d);
    en = e; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    en = 1'b0; we = 4'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    req(1'b1, w, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    req(1'b1, 4'h0, a, 32'h0);
  endtask

  // Literal check of a DUT value, also pinning the model's read value when asked.
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp,
                     input bit pin_model);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
    if (pin_model) begin
      tests++;
      if (m_rdata !== exp) begin
        fails++;
        $display("FAIL %s_model got=%h want=%h", name, m_rdata, exp);
      end
    end
  endtask

  initial begin
    // Reset for two edges, then release just after an edge.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    lit("reset_rdata", rdata, 32'h0, 1'b1);
    lit("reset_led", {16'h0, led}, 32'h0, 1'b0);
    lit("reset_num", num, 32'h0, 1'b0);

    // Timer: read sampled at the 10th edge after the last reset edge sees 9.
    repeat (9) @(posedge clk);
    #1 rd(CB + 32'h8);
    lit("timer_c10", rdata, 32'd9, 1'b1);

    // RAM full-word write then read.
    wr(32'h1c00_0000, 4'hf, 32'h1234_5678);
    rd(32'h1c00_0000);
    lit("ram_word", rdata, 32'h1234_5678, 1'b1);

    // Byte lanes, plus alias through unchecked upper address bits.
    wr(32'h1c00_0010, 4'hf, 32'haabb_ccdd);
    wr(32'h1c00_0010, 4'b0101, 32'h1122_3344);
    rd(32'h1c00_0010);
    lit("ram_lanes", rdata, 32'haa22_cc44, 1'b1);
    rd(32'h0000_0010);
    lit("ram_alias", rdata, 32'haa22_cc44, 1'b1);

    // Back-to-back writes then reads, and rdata held across a write and idle.
    wr(32'h1c00_0020, 4'hf, 32'h0000_0055);
    wr(32'h1c00_0024, 4'hf, 32'h0000_0066);
    rd(32'h1c00_0020);
    lit("b2b_rd0", rdata, 32'h55, 1'b1);
    rd(32'h1c00_0024);
    lit("b2b_rd1", rdata, 32'h66, 1'b1);
    wr(32'h1c00_0028, 4'hf, 32'h7777_7777);
    @(posedge clk); #1;
    lit("rdata_hold", rdata, 32'h66, 1'b1);

    // Timer wrap: value after write edge is fffffffe, then ffffffff, then 0.
    wr(CB + 32'h8, 4'hf, 32'hffff_fffe);
    rd(CB + 32'h8);
    lit("timer_w0", rdata, 32'hffff_fffe, 1'b1);
    rd(CB + 32'h8);
    lit("timer_w1", rdata, 32'hffff_ffff, 1'b1);
    rd(CB + 32'h8);
    lit("timer_wrap", rdata, 32'h0, 1'b1);

    // Timer partial write: unwritten lanes take old+1 (0x100 -> 0x101 -> 0x1aa).
    wr(CB + 32'h8, 4'hf, 32'h0000_0100);
    wr(CB + 32'h8, 4'b0001, 32'hffff_ffaa);
    rd(CB + 32'h8);
    lit("timer_lane", rdata, 32'h0000_01aa, 1'b1);

    // LED keeps low 16 bits.
    wr(CB, 4'hf, 32'hdead_beef);
    lit("led_port", {16'h0, led}, 32'h0000_beef, 1'b0);
    rd(CB);
    lit("led_read", rdata, 32'h0000_beef, 1'b1);

    // Switch: write ignored; new value visible on a read two edges later.
    wr(CB + 32'h4, 4'hf, 32'hffff_ffff);
    sw = 8'h5a;
    rd(CB + 32'h4);
    lit("switch_old", rdata, 32'h0, 1'b1);
    rd(CB + 32'h4);
    lit("switch_new", rdata, 32'h0000_005a, 1'b1);

    // Scratch and NUM.
    wr(CB + 32'hc, 4'hf, 32'hcafe_f00d);
    wr(CB + 32'h10, 4'b0011, 32'h8765_4321);
    lit("num_port", num, 32'h0000_4321, 1'b0);
    rd(CB + 32'hc);
    lit("scratch_read", rdata, 32'hcafe_f00d, 1'b1);

    // Unmapped offset.
    wr(CB + 32'h100, 4'hf, 32'h1111_1111);
    rd(CB + 32'h100);
    lit("unmapped", rdata, 32'h0, 1'b1);

    // Reset mid-stream with a RAM write in the same cycle: reset wins.
    rd(CB + 32'hc);
    lit("pre_reset", rdata, 32'hcafe_f00d, 1'b1);
    reset = 1'b1;
    wr(32'h1c00_0000, 4'hf, 32'hffff_ffff);
    reset = 1'b0;
    lit("rst_rdata", rdata, 32'h0, 1'b1);
    lit("rst_led", {16'h0, led}, 32'h0, 1'b0);
    rd(CB + 32'h8);
    lit("rst_timer", rdata, 32'h0, 1'b1);
    rd(32'h1c00_0000);
    lit("rst_nowrite", rdata, 32'h1234_5678, 1'b1);

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
